// File: rtl/i2c_xyz_poller.sv
// Periodic X/Y/Z register poller driving a byte-level I2C master: pointer write,
// repeated-start read per axis, atomic three-axis commit, bounded retries and sticky fault.
module i2c_xyz_poller #(
    parameter logic [6:0]  DEV_ADDR  = 7'h53,
    parameter logic [7:0]  REG_X     = 8'h32,
    parameter int unsigned POLL_DIV  = 100000,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        source_clk,
    input  logic        arst,
    input  logic        enable,
    output logic        m_start,
    output logic        m_ten,
    output logic        m_ren,
    output logic [7:0]  m_data_in,
    input  logic [15:0] m_data_out,
    input  logic        m_request,
    input  logic        m_error,
    output logic [15:0] data_x,
    output logic [15:0] data_y,
    output logic [15:0] data_z,
    output logic        xyz_valid,
    output logic        busy,
    output logic        fault,
    output logic [2:0]  dbg_state
);
    // Master handshake: controls are held steady while a phase is active; m_request
    // (byte accepted / read data valid) or m_error is a one-cycle strobe that ends it.
    localparam int DIV_W = $clog2(POLL_DIV);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_TICK, W_ADDR, W_REG, R_ADDR, R_DATA, BACKOFF, FAULT
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [WD_W-1:0]  wd;
    logic [RT_W-1:0]  retry;
    logic [3:0]       bo_cnt;
    logic [1:0]       axis;
    logic [15:0]      stg_x, stg_y;
    logic             tick, wd_hit, xfer_err, active;

    assign tick      = enable && (div_cnt == DIV_W'(POLL_DIV - 1));
    assign wd_hit    = (wd == WD_W'(TIMEOUT));
    assign xfer_err  = m_error || wd_hit;
    assign active    = (state == W_ADDR) || (state == W_REG) || (state == R_ADDR) || (state == R_DATA);
    assign dbg_state = state;

    // Packed as {busy, m_start, m_ten, m_ren, m_data_in} for the state being entered.
    function automatic logic [11:0] ctrl_for(input state_t s, input logic [1:0] ax);
        case (s)
            W_ADDR:  ctrl_for = {4'b1110, DEV_ADDR, 1'b0};
            W_REG:   ctrl_for = {4'b1010, REG_X + {5'b0, ax, 1'b0}};
            R_ADDR:  ctrl_for = {4'b1101, DEV_ADDR, 1'b1};
            R_DATA:  ctrl_for = {4'b1001, 8'h00};
            BACKOFF: ctrl_for = {4'b1000, 8'h00};
            default: ctrl_for = 12'h000;
        endcase
    endfunction

    always_ff @(posedge source_clk or posedge arst) begin
        if (arst) begin
            div_cnt <= '0;
        end else if (!enable || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge source_clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            wd        <= '0;
            retry     <= '0;
            bo_cnt    <= '0;
            axis      <= '0;
            stg_x     <= '0;
            stg_y     <= '0;
            data_x    <= '0;
            data_y    <= '0;
            data_z    <= '0;
            xyz_valid <= 1'b0;
            fault     <= 1'b0;
            {busy, m_start, m_ten, m_ren, m_data_in} <= '0;
        end else begin
            xyz_valid <= 1'b0;
            if (active && !wd_hit) wd <= wd + 1'b1;
            case (state)
                IDLE: if (enable) state <= WAIT_TICK;
                WAIT_TICK: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick) begin
                        axis  <= 2'd0;
                        state <= W_ADDR;
                        {busy, m_start, m_ten, m_ren, m_data_in} <= ctrl_for(W_ADDR, 2'd0);
                    end
                end
                W_ADDR, W_REG, R_ADDR, R_DATA: begin
                    // An error strobe outranks a simultaneous request, so nothing is latched.
                    if (xfer_err) begin
                        wd <= '0;
                        if (retry < RT_W'(MAX_RETRY)) begin
                            retry  <= retry + 1'b1;
                            bo_cnt <= '0;
                            state  <= BACKOFF;
                            {busy, m_start, m_ten, m_ren, m_data_in} <= ctrl_for(BACKOFF, axis);
                        end else begin
                            fault <= 1'b1;
                            state <= FAULT;
                            {busy, m_start, m_ten, m_ren, m_data_in} <= '0;
                        end
                    end else if (m_request) begin
                        wd <= '0;
                        case (state)
                            W_ADDR: begin
                                state <= W_REG;
                                {busy, m_start, m_ten, m_ren, m_data_in} <= ctrl_for(W_REG, axis);
                            end
                            W_REG: begin
                                state <= R_ADDR;
                                {busy, m_start, m_ten, m_ren, m_data_in} <= ctrl_for(R_ADDR, axis);
                            end
                            R_ADDR: begin
                                state <= R_DATA;
                                {busy, m_start, m_ten, m_ren, m_data_in} <= ctrl_for(R_DATA, axis);
                            end
                            R_DATA: begin
                                retry <= '0;
                                if (axis == 2'd0) stg_x <= m_data_out;
                                if (axis == 2'd1) stg_y <= m_data_out;
                                if (axis < 2'd2) begin
                                    axis  <= axis + 2'd1;
                                    state <= W_ADDR;
                                    {busy, m_start, m_ten, m_ren, m_data_in} <= ctrl_for(W_ADDR, axis);
                                end else begin
                                    data_x    <= stg_x;
                                    data_y    <= stg_y;
                                    data_z    <= m_data_out;
                                    xyz_valid <= 1'b1;
                                    state     <= WAIT_TICK;
                                    {busy, m_start, m_ten, m_ren, m_data_in} <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                BACKOFF: begin
                    if (bo_cnt == 4'd15) begin
                        state <= W_ADDR;
                        {busy, m_start, m_ten, m_ren, m_data_in} <= ctrl_for(W_ADDR, axis);
                    end else begin
                        bo_cnt <= bo_cnt + 4'd1;
                    end
                end
                FAULT: begin
                    if (!enable) begin
                        fault <= 1'b0;
                        retry <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_xyz_poller.md
# i2c_xyz_poller

Periodic transaction scheduler that sits between the application layer and the I2C master FSM. It sequences three register reads per sweep from a 3-axis sensor: X, Y and Z, each 16 bits. Every read is a pointer write followed by a repeated-start read. The block commits the three results together, retries failed transfers, and raises a sticky fault after repeated failures. It replaces hand-driven start/ten/ren sequencing when the design runs in continuous-measurement mode.

## Interface
Parameters:
- DEV_ADDR, 7'h53, 7-bit I2C slave address
- REG_X, 8'h32, pointer of X register; Y = REG_X+2, Z = REG_X+4
- POLL_DIV, 100000, source_clk cycles between sweep ticks (≥ 2)
- TIMEOUT, 65535, cycles without m_request in an active state before forced error
- MAX_RETRY, 3, retries per axis before fault

Ports:
- source_clk  in  1  system clock, all logic on rising edge
- arst  in  1  asynchronous, active-high reset
- enable  in  1  polling enable
- m_start  out  1  start / repeated-start request to master
- m_ten  out  1  transmit phase enable
- m_ren  out  1  receive phase enable
- m_data_in  out  8  byte handed to master
- m_data_out  in  16  word returned by master in read phase
- m_request  in  1  one-cycle master strobe: byte accepted / data valid
- m_error  in  1  one-cycle master NACK/bus error strobe
- data_x, data_y, data_z  out  16  last committed sample
- xyz_valid  out  1  one-cycle pulse on commit
- busy  out  1  high in any transaction state
- fault  out  1  sticky retry-exhaustion flag

## Operation
- Every output is registered and cleared to 0 by arst, including the data registers. The divider, axis index, retry counter, watchdog and state (IDLE) also reset.
- Divider counts 0..POLL_DIV-1 only while enable=1 and is cleared when enable=0. A tick is emitted on the cycle the count equals POLL_DIV-1.
- States: IDLE, WAIT_TICK, W_ADDR, W_REG, R_ADDR, R_DATA, BACKOFF, FAULT.
- IDLE: on enable=1 go to WAIT_TICK.
- WAIT_TICK:
  - On enable=0 go to IDLE.
  - On tick, set axis=0 and go to W_ADDR.
- W_ADDR: m_start=1, m_ten=1, m_data_in={DEV_ADDR,0}. On m_request go to W_REG.
- W_REG: m_ten=1, m_data_in=REG_X+2·axis. On m_request go to R_ADDR.
- R_ADDR: m_start=1, m_ren=1, m_data_in={DEV_ADDR,1}. On m_request go to R_DATA.
- R_DATA: m_ren=1. On m_request:
  - Latch m_data_out into staging[axis] and clear the retry counter.
  - If axis<2, increment axis and go to W_ADDR.
  - Otherwise copy staging to data_x/y/z, pulse xyz_valid, and go to WAIT_TICK.
- Error handling, in any of W_ADDR..R_DATA:
  - m_error=1 or watchdog = TIMEOUT counts as an error.
  - If retry < MAX_RETRY, increment retry and go to BACKOFF.
  - Otherwise go to FAULT.
- BACKOFF: all master controls 0 for 16 cycles, then W_ADDR for the same axis. Staging for earlier axes is kept.
- FAULT: fault=1 and all master controls 0. Exit to IDLE only when enable=0, which clears fault.
- Watchdog:
  - Cleared on every state change.
  - Increments each cycle in W_ADDR..R_DATA.
  - Saturates at TIMEOUT.
- busy=1 in W_ADDR..R_DATA and BACKOFF.

## Timing
- Tick to m_start=1 takes 1 cycle: the state register updates on the tick edge.
- m_request sampled high advances the state on the same edge, so the new master controls are visible the next cycle.
- Final R_DATA m_request: data_x/y/z update and xyz_valid=1 on the same edge; xyz_valid lasts exactly 1 cycle.
- m_request and m_error high in the same cycle: the error wins and no data is latched.
- Ticks arriving while busy or in FAULT are dropped and not queued. The divider keeps running.
- enable=0 mid-sweep is ignored until WAIT_TICK, so an in-flight sweep always completes or faults.
- The data registers never change except at the full commit; a partial sweep is never visible.
- arst mid-transaction drops all master controls to 0 asynchronously.

## Test plan
- **Clean sweep.** POLL_DIV=20, master model requests after 3 cycles and returns 16'h0102/0304/0506.
  - data_x=0102, data_y=0304, data_z=0506.
  - One xyz_valid pulse per sweep.
  - m_data_in sequence A6,32,A7,–,A6,34,A7,–,A6,36,A7.
- **Single error on Y pointer byte.** One error on that byte: 16-cycle BACKOFF, Y restarted from W_ADDR, commit still occurs, fault=0.
- **Persistent errors.** 4 consecutive errors on X: fault=1 after the 4th, no xyz_valid. enable=0 then returns to IDLE with fault=0.
- **Silent master.** TIMEOUT=50 and no m_request: error taken at the 50th watchdog cycle in W_ADDR, retry sequence observed.
- **Simultaneous strobes and tick overlap.**
  - m_request and m_error in the same R_DATA cycle: staging unchanged, retry taken.
  - Ticks during busy: no extra sweep starts.
- **Reset mid-sweep.** arst asserted in R_ADDR: all outputs 0 immediately, data registers 0, restart from IDLE.
